// File: rtl/seq_tx_1101_if.sv
// Handshake and serial-output bundle for the 1101 sync-pattern frame transmitter.
interface seq_tx_1101_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              y;
  logic              busy;
  logic              done;

  modport master (output start, data, input ready, y, busy, done);
  modport slave  (input start, data, output ready, y, busy, done);
endinterface

// File: rtl/seq_tx_1101.sv
// Serial frame transmitter: sync word 1101, DATA_W payload bits MSB-first, then GAP idle zeros.
// y/busy/done are registered and describe the bit currently on the line.
module seq_tx_1101 #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic         clk,
  input  logic         reset,
  seq_tx_1101_if.slave bus
);
  localparam int MAX_LEN = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                          : ((GAP > 4) ? GAP : 4);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [3:0]       SYNC_WORD   = 4'b1101;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PENULT = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] GAP_PENULT  = CNT_W'(GAP - 2);
  // A one-bit payload with no gap makes the very first data bit the frame's last bit.
  localparam logic DONE_FIRST_DATA = (GAP == 0) && (DATA_W == 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              y_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      y_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          y_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          cnt    <= '0;
          if (bus.start) begin
            state  <= S_SYNC;
            shreg  <= bus.data;
            y_q    <= SYNC_WORD[3];
            busy_q <= 1'b1;
          end
        end
        S_SYNC: begin
          if (cnt == SYNC_LAST) begin
            state  <= S_DATA;
            cnt    <= '0;
            y_q    <= shreg[DATA_W-1];
            shreg  <= shreg << 1;
            done_q <= DONE_FIRST_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
            y_q <= SYNC_WORD[2'd2 - cnt[1:0]];
          end
        end
        S_DATA: begin
          if (cnt == DATA_LAST) begin
            cnt <= '0;
            y_q <= 1'b0;
            if (GAP == 0) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b0;
            end else begin
              state  <= S_GAP;
              done_q <= (GAP == 1);
            end
          end else begin
            cnt    <= cnt + CNT_ONE;
            y_q    <= shreg[DATA_W-1];
            shreg  <= shreg << 1;
            done_q <= (GAP == 0) && (cnt == DATA_PENULT);
          end
        end
        S_GAP: begin
          y_q <= 1'b0;
          if (cnt == GAP_LAST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else begin
            cnt    <= cnt + CNT_ONE;
            done_q <= (cnt == GAP_PENULT);
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          y_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.y     = y_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_tx_1101.sv
// Scoreboard bench for seq_tx_1101: expected {y,busy,done,ready} per cycle is queued at accept time.
module tb_seq_tx_1101;
  localparam int L8 = 14;
  localparam int L4 = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [3:0] q8[$];
  logic [3:0] q4[$];

  seq_tx_1101_if #(.DATA_W(8)) bus8();
  seq_tx_1101_if #(.DATA_W(4)) bus4();

  seq_tx_1101 #(.DATA_W(8), .GAP(2)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_tx_1101 #(.DATA_W(4), .GAP(0)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // Overlapping 1101 Mealy detector on the 8-bit transmitter's line.
  logic [2:0] det_hist;
  logic       det_z;
  always @(posedge clk) begin
    if (reset) det_hist <= 3'b000;
    else       det_hist <= {det_hist[1:0], bus8.y};
  end
  assign det_z = (det_hist == 3'b110) && bus8.y;

  function automatic void push_frame8(input logic [7:0] d);
    logic [3:0] sw;
    logic       yb;
    sw = 4'b1101;
    for (int i = 0; i < L8; i++) begin
      if (i < 4)       yb = sw[3-i];
      else if (i < 12) yb = d[11-i];
      else             yb = 1'b0;
      q8.push_back({yb, 1'b1, (i == L8 - 1), 1'b0});
    end
  endfunction

  function automatic void push_frame4(input logic [3:0] d);
    logic [3:0] sw;
    logic       yb;
    sw = 4'b1101;
    for (int i = 0; i < L4; i++) begin
      if (i < 4) yb = sw[3-i];
      else       yb = d[7-i];
      q4.push_back({yb, 1'b1, (i == L4 - 1), 1'b0});
    end
  endfunction

  function automatic logic [3:0] pop8();
    if (q8.size() == 0) return 4'b0001;
    return q8.pop_front();
  endfunction

  function automatic logic [3:0] pop4();
    if (q4.size() == 0) return 4'b0001;
    return q4.pop_front();
  endfunction

  task automatic test_reset();
    logic [3:0] o;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = {bus8.y, bus8.busy, bus8.done, bus8.ready};
    n_total++;
    if (o !== 4'b0001) $display("FAIL reset8 ybdr got %b exp 0001", o);
    else n_pass++;
    o = {bus4.y, bus4.busy, bus4.done, bus4.ready};
    n_total++;
    if (o !== 4'b0001) $display("FAIL reset4 ybdr got %b exp 0001", o);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    q8.delete();
    q4.delete();
  endtask

  task automatic test_basic();
    logic [3:0] e, o;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      bus8.start = (c == 0);
      bus8.data  = (c == 0) ? 8'hA5 : 8'h5A;
      @(negedge clk);
      e = pop8();
      o = {bus8.y, bus8.busy, bus8.done, bus8.ready};
      n_total++;
      if (o !== e) $display("FAIL basic c=%0d ybdr got %b exp %b", c, o, e);
      else n_pass++;
      if (bus8.start && e[0]) push_frame8(bus8.data);
    end
  endtask

  task automatic test_busy_start();
    logic [3:0] e, o;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus8.start = (c == 0) || (c == 3) || (c == 10);
      bus8.data  = (c == 0) ? 8'hFF : 8'h00;
      @(negedge clk);
      e = pop8();
      o = {bus8.y, bus8.busy, bus8.done, bus8.ready};
      n_total++;
      if (o !== e) $display("FAIL busy_start c=%0d ybdr got %b exp %b", c, o, e);
      else n_pass++;
      if (bus8.start && e[0]) push_frame8(bus8.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e, o;
    int done_at[$];
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus8.start = (c < 30);
      bus8.data  = 8'h3C;
      @(negedge clk);
      e = pop8();
      o = {bus8.y, bus8.busy, bus8.done, bus8.ready};
      n_total++;
      if (o !== e) $display("FAIL back_to_back c=%0d ybdr got %b exp %b", c, o, e);
      else n_pass++;
      if (bus8.done === 1'b1) done_at.push_back(c);
      if (bus8.start && e[0]) push_frame8(bus8.data);
    end
    n_total++;
    if (done_at.size() != 2) $display("FAIL b2b_frames got %0d frames exp 2", done_at.size());
    else if (done_at[1] - done_at[0] != 15)
      $display("FAIL b2b_spacing got %0d exp 15", done_at[1] - done_at[0]);
    else n_pass++;
    bus8.start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] e, o;
    for (int c = 0; c < 28; c++) begin
      @(posedge clk); #1;
      reset      = (c == 6);
      bus8.start = (c == 0) || (c == 9);
      bus8.data  = (c == 0) ? 8'hA5 : 8'hC3;
      @(negedge clk);
      e = pop8();
      o = {bus8.y, bus8.busy, bus8.done, bus8.ready};
      n_total++;
      if (o !== e) $display("FAIL reset_mid c=%0d ybdr got %b exp %b", c, o, e);
      else n_pass++;
      if (reset) begin
        q8.delete();
        q4.delete();
      end else if (bus8.start && e[0]) begin
        push_frame8(bus8.data);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_gap0();
    logic [3:0] e, o;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      bus4.start = (c == 0);
      bus4.data  = (c == 0) ? 4'b1001 : 4'b0110;
      @(negedge clk);
      e = pop4();
      o = {bus4.y, bus4.busy, bus4.done, bus4.ready};
      n_total++;
      if (o !== e) $display("FAIL gap0 c=%0d ybdr got %b exp %b", c, o, e);
      else n_pass++;
      if (bus4.start && e[0]) push_frame4(bus4.data);
    end
  endtask

  task automatic test_loopback();
    logic [3:0] e, o;
    int pulses;
    pulses = 0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      bus8.start = (c == 0);
      bus8.data  = 8'h00;
      @(negedge clk);
      e = pop8();
      o = {bus8.y, bus8.busy, bus8.done, bus8.ready};
      n_total++;
      if (o !== e) $display("FAIL loopback c=%0d ybdr got %b exp %b", c, o, e);
      else n_pass++;
      n_total++;
      if (det_z !== (c == 4)) $display("FAIL detector c=%0d z got %b exp %b", c, det_z, (c == 4));
      else n_pass++;
      if (det_z === 1'b1) pulses++;
      if (bus8.start && e[0]) push_frame8(bus8.data);
    end
    n_total++;
    if (pulses != 1) $display("FAIL detector_pulses got %0d exp 1", pulses);
    else n_pass++;
  endtask

  initial begin
    reset      = 1'b1;
    bus8.start = 1'b0;
    bus8.data  = '0;
    bus4.start = 1'b0;
    bus4.data  = '0;
    test_reset();
    test_basic();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
